// File: rtl/ula_ctrl_seq.sv
// ula_ctrl_seq: registered ALU-control decoder with mult/div busy/done sequencing.
// Decodes opULA/opcode/funct into an ALU control code, holds it in a register,
// and keeps the pipeline stalled while a multi-cycle mult/div is in flight.
module ula_ctrl_seq #(
  parameter int unsigned CTRL_W  = 6,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [1:0]        opULA,
  output logic              ready,
  output logic [CTRL_W-1:0] controle,
  output logic              ctrl_valid,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int unsigned CODE_W  = 6;

  localparam logic [CNT_W-1:0]  MUL_LOAD  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0]  DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic              MUL_ONE   = (MUL_LAT == 1);
  localparam logic              DIV_ONE   = (DIV_LAT == 1);
  localparam logic [CODE_W-1:0] CODE_MUL  = CODE_W'(2);
  localparam logic [CODE_W-1:0] CODE_DIV  = CODE_W'(3);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_MULDIV = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CTRL_W-1:0]   r_controle;
  logic                r_ctrl_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_illegal;

  logic                w_legal;
  logic [CODE_W-1:0]   w_code;
  logic                w_ready;
  logic                w_accept;

  // Handshake: a finishing mult/div frees the slot in its last busy cycle
  assign w_ready  = !r_busy || r_done;
  assign w_accept = valid_in && w_ready;

  assign ready      = w_ready;
  assign controle   = r_controle;
  assign ctrl_valid = r_ctrl_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign illegal    = r_illegal;

  // Decode: opULA override, then R-type funct, then opcode table
  always_comb begin
    w_legal = 1'b1;
    w_code  = '0;
    case (opULA)
      2'b01: w_code = CODE_W'(0);
      2'b10: w_code = CODE_W'(33);
      2'b11: w_code = CODE_W'(31);
      default: begin
        if (opcode == 6'b000000) begin
          case (funct)
            6'b000000: w_code = CODE_W'(0);
            6'b000001: w_code = CODE_W'(1);
            6'b000010: w_code = CODE_W'(2);
            6'b000011: w_code = CODE_W'(3);
            6'b100000: w_code = CODE_W'(4);
            6'b100001: w_code = CODE_W'(5);
            6'b100010: w_code = CODE_W'(6);
            6'b100011: w_code = CODE_W'(7);
            6'b110000: w_code = CODE_W'(12);
            6'b110001: w_code = CODE_W'(11);
            default:   w_legal = 1'b0;
          endcase
        end else begin
          case (opcode)
            6'b000001: w_code = CODE_W'(0);
            6'b000010: w_code = CODE_W'(1);
            6'b000011: w_code = CODE_W'(3);
            6'b000100: w_code = CODE_W'(2);
            6'b001001: w_code = CODE_W'(7);
            6'b001010: w_code = CODE_W'(5);
            6'b001011: w_code = CODE_W'(4);
            6'b010000: w_code = CODE_W'(13);
            6'b011100: w_code = CODE_W'(12);
            6'b011110: w_code = CODE_W'(11);
            6'b100000: w_code = CODE_W'(13);
            6'b110000: w_code = CODE_W'(8);
            6'b111000: w_code = CODE_W'(9);
            default:   w_legal = 1'b0;
          endcase
        end
      end
    endcase
  end

  // Control register, pulses and mult/div sequencer; an accept overrides countdown results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_controle   <= '0;
      r_ctrl_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_ctrl_valid <= 1'b0;
      r_illegal    <= 1'b0;

      case (r_state)
        S_MULDIV: begin
          if (r_cnt != '0) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_done <= (r_cnt == CNT_W'(1));
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_accept) begin
        if (w_legal) begin
          r_controle   <= CTRL_W'(w_code);
          r_ctrl_valid <= 1'b1;
          if (w_code == CODE_MUL) begin
            r_state <= S_MULDIV;
            r_cnt   <= MUL_LOAD;
            r_busy  <= 1'b1;
            r_done  <= MUL_ONE;
          end else if (w_code == CODE_DIV) begin
            r_state <= S_MULDIV;
            r_cnt   <= DIV_LOAD;
            r_busy  <= 1'b1;
            r_done  <= DIV_ONE;
          end
        end else begin
          r_illegal <= 1'b1;
        end
      end
    end
  end

endmodule
